// File: rtl/imem_load_controller.sv
// imem_load_controller
// Owns the single address port of the byte-addressed instruction memory and
// shares it between IF fetch and a byte-wide program-load stream. In IDLE the
// port serves fetch combinationally. A load checks its range and alignment,
// assembles each big-endian word from four bytes and then writes those bytes
// over four cycles. While a load runs, IF is stalled on NOP.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   load_start        one-cycle load request, sampled in IDLE only
//   load_base         byte address of the first word (sampled with load_start)
//   load_count        number of 32-bit words (sampled with load_start)
//   byte_valid/data   loader byte stream, MSB of each word first
//   byte_ready        a byte is accepted this cycle (COLLECT)
//   if_pc/if_inst     fetch address / instruction returned to IF
//   if_stall          IF must hold its PC
//   mem_addr          memory address (fetch or load)
//   mem_wr_en/data    byte write strobe and data
//   mem_rd_data       combinational read word at mem_addr
//   busy, done, err   load in progress, end-of-load pulse, sticky reject flag
module imem_load_controller #(
  parameter int          MEM_SIZE = 1024,
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] NOP      = 32'hE0000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [15:0]       load_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic [ADDR_W-1:0] if_pc,
  output logic [31:0]       if_inst,
  output logic              if_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wr_data,
  input  logic [31:0]       mem_rd_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHECK   = 3'd1,
    COLLECT = 3'd2,
    WRITE   = 3'd3,
    DONE    = 3'd4
  } state_t;

  // End-of-load address is computed three bits wider so 4*count cannot wrap.
  localparam int                EXT_W     = ADDR_W + 3;
  localparam logic [EXT_W-1:0]  MEM_LIMIT = EXT_W'(MEM_SIZE);

  state_t            state_r;
  state_t            state_s;
  logic [ADDR_W-1:0] word_addr_r;
  logic [15:0]       remaining_r;
  logic [31:0]       word_r;
  logic [1:0]        byte_cnt_r;
  logic [1:0]        k_r;
  logic              err_r;
  logic [EXT_W-1:0]  end_addr_s;
  logic              reject_s;

  // Range/alignment check on the latched base and count (used in CHECK).
  always_comb begin
    end_addr_s = EXT_W'(word_addr_r) + EXT_W'({remaining_r, 2'b00});
    reject_s   = (word_addr_r[1:0] != 2'b00) || (end_addr_s > MEM_LIMIT);
  end

  // State register and load datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      word_addr_r <= '0;
      remaining_r <= 16'd0;
      word_r      <= 32'd0;
      byte_cnt_r  <= 2'd0;
      k_r         <= 2'd0;
      err_r       <= 1'b0;
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (load_start) begin
            word_addr_r <= load_base;
            remaining_r <= load_count;
            byte_cnt_r  <= 2'd0;
            k_r         <= 2'd0;
            err_r       <= 1'b0;
          end
        end
        CHECK: begin
          if (reject_s) begin
            err_r <= 1'b1;
          end
        end
        COLLECT: begin
          // Shift in MSB first; the counter wraps to 0 after the 4th byte.
          if (byte_valid) begin
            word_r     <= {word_r[23:0], byte_data};
            byte_cnt_r <= byte_cnt_r + 2'd1;
            k_r        <= 2'd0;
          end
        end
        WRITE: begin
          k_r <= k_r + 2'd1;
          if (k_r == 2'd3) begin
            word_addr_r <= word_addr_r + ADDR_W'(4);
            remaining_r <= remaining_r - 16'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state logic and state-decoded outputs; fetch path is combinational.
  always_comb begin
    state_s     = state_r;
    byte_ready  = 1'b0;
    if_inst     = NOP;
    if_stall    = 1'b1;
    mem_addr    = word_addr_r;
    mem_wr_en   = 1'b0;
    mem_wr_data = 8'h00;
    busy        = 1'b1;
    done        = 1'b0;
    err         = err_r;
    case (state_r)
      IDLE: begin
        busy     = 1'b0;
        if_stall = 1'b0;
        mem_addr = if_pc;
        if_inst  = mem_rd_data;
        if (load_start) begin
          state_s = CHECK;
        end else begin
          state_s = IDLE;
        end
      end
      CHECK: begin
        if (reject_s || (remaining_r == 16'd0)) begin
          state_s = DONE;
        end else begin
          state_s = COLLECT;
        end
      end
      COLLECT: begin
        byte_ready = 1'b1;
        if (byte_valid && (byte_cnt_r == 2'd3)) begin
          state_s = WRITE;
        end else begin
          state_s = COLLECT;
        end
      end
      WRITE: begin
        mem_wr_en = 1'b1;
        mem_addr  = word_addr_r + ADDR_W'(k_r);
        case (k_r)
          2'd0:    mem_wr_data = word_r[31:24];
          2'd1:    mem_wr_data = word_r[23:16];
          2'd2:    mem_wr_data = word_r[15:8];
          default: mem_wr_data = word_r[7:0];
        endcase
        if (k_r == 2'd3) begin
          if (remaining_r == 16'd1) begin
            state_s = DONE;
          end else begin
            state_s = COLLECT;
          end
        end else begin
          state_s = WRITE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_imem_load_controller.sv
module tb_imem_load_controller;
  localparam int          ADDR_W = 32;
  localparam logic [31:0] NOP    = 32'hE0000000;

  logic              clk;
  logic              rst;
  logic              load_start;
  logic [ADDR_W-1:0] load_base;
  logic [15:0]       load_count;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic [ADDR_W-1:0] if_pc;
  logic [31:0]       if_inst;
  logic              if_stall;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr_en;
  logic [7:0]        mem_wr_data;
  logic [31:0]       mem_rd_data;
  logic              busy;
  logic              done;
  logic              err;

  logic [7:0]  mem [0:1023];
  logic [9:0]  ra;
  logic [39:0] exp_q [$];
  logic [39:0] mon_e;
  int          checks;
  int          errors;
  int          run_len;

  imem_load_controller #(.MEM_SIZE(1024), .ADDR_W(ADDR_W), .NOP(NOP)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_base(load_base),
    .load_count(load_count), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .if_pc(if_pc), .if_inst(if_inst),
    .if_stall(if_stall), .mem_addr(mem_addr), .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .busy(busy),
    .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: byte writes on the clock edge, combinational big-endian read.
  always @(posedge clk) begin
    if (mem_wr_en && (mem_addr < 32'd1024)) mem[mem_addr[9:0]] <= mem_wr_data;
  end

  always_comb begin
    ra = mem_addr[9:0];
    mem_rd_data = {mem[ra], mem[ra + 10'd1], mem[ra + 10'd2], mem[ra + 10'd3]};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: each write must match the next expected (addr, data),
  // and writes must come in unbroken runs of exactly 4 cycles.
  always @(negedge clk) begin
    if (rst) begin
      run_len = 0;
    end else if (mem_wr_en) begin
      run_len++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h, expected no write", mem_addr, mem_wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_addr", mem_addr, mon_e[39:8]);
        chk("write_data", {24'h0, mem_wr_data}, {24'h0, mon_e[7:0]});
      end
    end else begin
      if (run_len != 0) chk("write_run_len", run_len, 32'd4);
      run_len = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] addr, input logic [31:0] w);
    exp_q.push_back({addr,          w[31:24]});
    exp_q.push_back({addr + 32'd1,  w[23:16]});
    exp_q.push_back({addr + 32'd2,  w[15:8]});
    exp_q.push_back({addr + 32'd3,  w[7:0]});
  endtask

  task automatic start_load(input logic [31:0] base, input logic [15:0] cnt);
    load_start = 1'b1;
    load_base  = base;
    load_count = cnt;
    step();
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (byte_ready) begin
        ok = 1'b1;
        step();
        break;
      end
      step();
    end
    byte_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL byte_accept_timeout: got no byte_ready, expected accept of %h", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send_byte(w[31:24]); repeat (gap) step();
    send_byte(w[23:16]); repeat (gap) step();
    send_byte(w[15:8]);  repeat (gap) step();
    send_byte(w[7:0]);
  endtask

  // Called in WRITE k=0 of the last word: done must appear 4 cycles later.
  task automatic wait_done(input string name);
    int n;
    bit seen;
    bit nop_ok;
    seen = 1'b0;
    nop_ok = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy && (if_inst !== NOP || if_stall !== 1'b1)) nop_ok = 1'b0;
      if (done) begin
        seen = 1'b1;
        n = i;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done, expected done pulse", name);
    end else begin
      chk({name, "_latency"}, n, 32'd4);
    end
    chk({name, "_nop_stall"}, {31'd0, nop_ok}, 32'd1);
    step();
  endtask

  task automatic reject_check(input string name, input logic [31:0] base, input logic [15:0] cnt,
                              input logic exp_err);
    start_load(base, cnt);
    chk({name, "_busy_T1"}, {31'd0, busy}, 32'd1);
    chk({name, "_err_cleared_T1"}, {31'd0, err}, 32'd0);
    chk({name, "_done_T1"}, {31'd0, done}, 32'd0);
    step();
    chk({name, "_done_T2"}, {31'd0, done}, 32'd1);
    chk({name, "_err_T2"}, {31'd0, err}, {31'd0, exp_err});
    step();
    chk({name, "_busy_T3"}, {31'd0, busy}, 32'd0);
    chk({name, "_err_T3"}, {31'd0, err}, {31'd0, exp_err});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; errors = 0; run_len = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    rst = 1'b1; load_start = 1'b0; load_base = '0; load_count = 16'd0;
    byte_valid = 1'b0; byte_data = 8'h00; if_pc = 32'h10;
    step(); step();

    // Reset state
    chk("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    chk("rst_mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
    chk("rst_mem_wr_data", {24'd0, mem_wr_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_if_stall", {31'd0, if_stall}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h10);
    rst = 1'b0;

    // Idle fetch
    mem[0] = 8'hE3; mem[1] = 8'hA0; mem[2] = 8'h00; mem[3] = 8'h14;
    if_pc = 32'd0;
    step();
    chk("idle_if_inst", if_inst, 32'hE3A00014);
    chk("idle_if_stall", {31'd0, if_stall}, 32'd0);
    if_pc = 32'h24;
    #1;
    chk("idle_mem_addr", mem_addr, 32'h24);

    // Single-word load over cleared memory
    for (int i = 0; i < 4; i++) mem[i] = 8'h00;
    push_word(32'd0, 32'hE3A00014);
    start_load(32'd0, 16'd1);
    chk("single_check_stall", {31'd0, if_stall}, 32'd1);
    chk("single_check_nop", if_inst, NOP);
    send_word(32'hE3A00014, 0);
    wait_done("single");
    chk("single_idle_stall", {31'd0, if_stall}, 32'd0);
    chk("single_idle_busy", {31'd0, busy}, 32'd0);
    if_pc = 32'd0;
    #1;
    chk("single_fetch", if_inst, 32'hE3A00014);

    // Multi-word load with 2-cycle byte gaps
    push_word(32'd64, 32'h11223344);
    push_word(32'd68, 32'h55667788);
    push_word(32'd72, 32'h99AABBCC);
    start_load(32'd64, 16'd3);
    send_word(32'h11223344, 2); repeat (2) step();
    send_word(32'h55667788, 2); repeat (2) step();
    send_word(32'h99AABBCC, 2);
    wait_done("multi");
    chk("multi_err", {31'd0, err}, 32'd0);
    if_pc = 32'd68;
    #1;
    chk("multi_fetch", if_inst, 32'h55667788);

    // Range and alignment rejects, then count-0
    reject_check("rej_range", 32'd1020, 16'd2, 1'b1);
    reject_check("rej_align", 32'd2, 16'd1, 1'b1);
    reject_check("count0", 32'd0, 16'd0, 1'b0);

    // Last word in memory exactly fits
    push_word(32'd1020, 32'hCAFEF00D);
    start_load(32'd1020, 16'd1);
    send_word(32'hCAFEF00D, 0);
    wait_done("edge_fit");
    chk("edge_fit_err", {31'd0, err}, 32'd0);

    // Reset mid-load: two words written, two bytes of the third collected
    for (int i = 128; i < 140; i++) mem[i] = 8'h55;
    push_word(32'd128, 32'hA1B2C3D4);
    push_word(32'd132, 32'hE5F60718);
    start_load(32'd128, 16'd3);
    send_word(32'hA1B2C3D4, 0);
    send_word(32'hE5F60718, 0);
    send_byte(8'h01);
    send_byte(8'h02);
    rst = 1'b1;
    step();
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_stall", {31'd0, if_stall}, 32'd0);
    chk("midrst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    if_pc = 32'd128; #1;
    chk("midrst_word0", if_inst, 32'hA1B2C3D4);
    if_pc = 32'd132; #1;
    chk("midrst_word1", if_inst, 32'hE5F60718);
    if_pc = 32'd136; #1;
    chk("midrst_untouched", if_inst, 32'h55555555);
    step();

    // load_start during COLLECT is ignored
    push_word(32'd256, 32'h9ABCDEF0);
    start_load(32'd256, 16'd1);
    send_byte(8'h9A);
    send_byte(8'hBC);
    start_load(32'd512, 16'd5);
    send_byte(8'hDE);
    send_byte(8'hF0);
    wait_done("ignore_start");
    step(); step();
    chk("ignore_start_busy", {31'd0, busy}, 32'd0);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_load_controller.md
# imem_load_controller

Sequencer and port arbiter in front of the byte-addressed instruction memory (4 bytes per 32-bit instruction, big-endian: byte at address A is instruction bits [31:24]). It owns the memory's single address port. It shares that port between the IF stage fetch path and a program-load stream that writes bytes into memory. While a load runs, it holds the pipeline on a NOP, then returns the port to fetch.

## Interface
Parameters:
- MEM_SIZE, 1024: instruction memory size in bytes.
- ADDR_W, 32: address and PC width.
- NOP, 32'hE0000000: instruction returned to IF while stalled.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- load_start  in  1  single-cycle request to begin a load; sampled only in IDLE.
- load_base  in  ADDR_W  byte address of the first word; sampled with load_start.
- load_count  in  16  number of 32-bit words to load; sampled with load_start.
- byte_valid  in  1  loader byte available.
- byte_data  in  8  loader byte, most significant byte of each word first.
- byte_ready  out  1  controller accepts a byte this cycle.
- if_pc  in  ADDR_W  fetch address from IF.
- if_inst  out  32  instruction to IF.
- if_stall  out  1  IF must hold its PC.
- mem_addr  out  ADDR_W  address to instruction memory.
- mem_wr_en  out  1  byte write strobe.
- mem_wr_data  out  8  byte to write.
- mem_rd_data  in  32  combinational read word at mem_addr.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse at load end, whether successful or rejected.
- err  out  1  sticky flag for a rejected load.

## Operation
- States: IDLE, CHECK, COLLECT, WRITE, DONE.
- IDLE:
  - mem_addr = if_pc; if_inst = mem_rd_data; if_stall = 0; byte_ready = 0.
  - On load_start: latch base and count, clear err, go to CHECK.
- CHECK (1 cycle): the load is rejected if any of the following holds:
  - load_base[1:0] != 0;
  - load_base + 4*load_count > MEM_SIZE. Compute this in ADDR_W+3 bits; it must not wrap.
  - On reject: err = 1, go to DONE with no writes.
  - If count == 0: go to DONE with no writes.
  - Otherwise: go to COLLECT.
- COLLECT:
  - byte_ready = 1.
  - Each valid&ready cycle shifts byte_data into a 32-bit word register, MSB first.
  - After the 4th byte, go to WRITE.
- WRITE (exactly 4 cycles, k = 0..3):
  - mem_wr_en = 1; mem_addr = word_addr + k; mem_wr_data = word[31-8k -: 8].
  - After k = 3: word_addr += 4 and remaining -= 1. If remaining reaches 0, go to DONE; else go to COLLECT.
- DONE (1 cycle): done = 1, then go to IDLE.
- Outside IDLE:
  - if_stall = 1 and if_inst = NOP.
  - load_start is ignored.
  - In states other than WRITE, mem_addr = latched word_addr and mem_wr_en = 0.
- busy = 1 in CHECK, COLLECT, WRITE and DONE.
- err is cleared only by rst or by the next accepted load_start.

## Timing
- Reset values: state IDLE, byte_ready 0, mem_wr_en 0, mem_wr_data 0, busy 0, done 0, err 0, if_stall 0. mem_addr follows if_pc immediately after reset.
- Fetch path in IDLE is zero-latency combinational.
- load_start accepted at edge T: busy = 1 from T+1; CHECK occupies T+1; COLLECT starts at T+2.
- Minimum per word is 8 cycles (4 accepts + 4 writes). Byte gaps extend COLLECT only; WRITE is never stretched.
- Last write at cycle W: done = 1 at W+1; IDLE and if_stall = 0 at W+2.
- Rejected or count-0 load: done at T+2, busy low at T+3.
- rst mid-load: IDLE on the next edge. Bytes already written stay in memory; a partially assembled word is discarded; err = 0.
- byte_valid while byte_ready = 0 is not consumed. The source must hold the byte.

## Test plan
- Idle fetch: memory preloaded with 0xE3A00014 at 0..3, if_pc = 0 → if_inst = 0xE3A00014, if_stall = 0, no writes.
- Single-word load: base 0, count 1, bytes E3,A0,00,14 back-to-back → writes (0,E3),(1,A0),(2,00),(3,14) on 4 consecutive cycles. done 1 cycle later; if_inst = NOP while busy; then fetch at 0 returns 0xE3A00014.
- Multi-word with gaps: base 64, count 3, byte_valid deasserted 2 cycles between every byte → 12 writes at 64..75 in order, each WRITE block exactly 4 cycles, err = 0.
- Range and alignment rejects (MEM_SIZE = 1024):
  - base 1020, count 2 → err = 1, no mem_wr_en, done at T+2.
  - base 2, count 1 → same.
  - Then base 0, count 0 → err cleared, done at T+2.
- Reset mid-load: count 3, assert rst after second word's WRITE plus 2 bytes of the third → IDLE next edge, busy 0, addresses base..base+7 hold new data, base+8.. unchanged.
- load_start pulsed during COLLECT → ignored; latched base and count are unchanged.
